// File: rtl/seq_mul_pkg.sv
// Shared types and constants for the seq_mul shift-and-add multiplier.
// The optional SEQ_MUL_SIGNED_EN build lives entirely in seq_mul.sv.
package seq_mul_pkg;

  localparam int SEQ_MUL_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bits needed to hold an iteration count running from w down to 1.
  function automatic int count_bits(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/seq_mul.sv
// seq_mul: radix-2 shift-and-add multiplier, one iteration per clock, WIDTH iterations.
// Define SEQ_MUL_SIGNED_EN for two's complement operands; the default build is unsigned.
module seq_mul
  import seq_mul_pkg::*;
#(
  parameter int WIDTH = SEQ_MUL_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out
);

  localparam int            CW    = count_bits(WIDTH);
  localparam logic [CW-1:0] ITERS = CW'(WIDTH);

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   acc_hi;
  logic [WIDTH-1:0]   mplr;
  logic [CW-1:0]      count;
  logic [WIDTH:0]     sum;
  logic [WIDTH-1:0]   acc_hi_nxt;
  logic [WIDTH-1:0]   mplr_nxt;
  logic [2*WIDTH-1:0] product;
  logic [2*WIDTH-1:0] result;
  logic [2*WIDTH-1:0] out_q;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic               accept;
  logic               last_iter;

  assign accept    = in_valid && in_ready;
  assign last_iter = (state == RUN) && (count == CW'(1));

  // NOTE: every signal driven in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = RUN;
      end
      RUN: begin
        if (last_iter) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // One iteration: the multiplier LSB gates an add into the upper half, the carry is
  // kept, then {carry, acc_hi, mplr} shifts right so the product fills in from the top.
  always_comb begin
    sum        = {1'b0, acc_hi} + (mplr[0] ? {1'b0, mcand} : '0);
    acc_hi_nxt = sum[WIDTH:1];
    mplr_nxt   = {sum[0], mplr[WIDTH-1:1]};
    product    = {acc_hi_nxt, mplr_nxt};
  end

`ifdef SEQ_MUL_SIGNED_EN
  logic neg_q;

  // The magnitude of the most negative value is its own bit pattern read as unsigned.
  assign a_mag  = a[WIDTH-1] ? -a : a;
  assign b_mag  = b[WIDTH-1] ? -b : b;
  assign result = neg_q ? -product : product;

  always_ff @(posedge clk) begin
    if (rst) begin
      neg_q <= 1'b0;
    end else if (accept) begin
      neg_q <= a[WIDTH-1] ^ b[WIDTH-1];
    end
  end
`else
  assign a_mag  = a;
  assign b_mag  = b;
  assign result = product;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: datapath registers are reset too, because out must read zero straight after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand  <= '0;
      acc_hi <= '0;
      mplr   <= '0;
      count  <= '0;
      out_q  <= '0;
    end else if (accept) begin
      mcand  <= a_mag;
      mplr   <= b_mag;
      acc_hi <= '0;
      count  <= ITERS;
    end else if (state == RUN) begin
      acc_hi <= acc_hi_nxt;
      mplr   <= mplr_nxt;
      count  <= count - 1'b1;
      // The final iteration's product lands in out on the same edge that enters DONE.
      if (last_iter) out_q <= result;
    end
  end

  assign out = out_q;

endmodule
